button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Front end that produces the button/switch control inputs the counter FSM consumes.
//  Per channel: 2-FF sync, debounce, then clean level, 1-cycle press/release pulses and a sticky pending flag.
//  Sits between board keys (raw, bouncing) and the FSM, in the 50 MHz clk_i domain.
//  pend_o/clr_i handshake lets the slow 4 Hz FSM domain consume events without loss.
// PARAMETERS
//  N_BTN          3          number of independent channels
//  DEB_CYCLES     1000000    stable-sample count before a level change is accepted (20 ms @ 50 MHz), >=2
//  ACTIVE_LOW     1          1: btn_i low = pressed (board keys); 0: high = pressed
//  REPEAT_DELAY   25000000   auto-repeat first-repeat delay, clocks (used only with BTN_AUTOREPEAT_EN)
//  REPEAT_PERIOD  12500000   auto-repeat interval, clocks (used only with BTN_AUTOREPEAT_EN)
// PORTS
//  clk_i      in   1       system clock, 50 MHz
//  rstn       in   1       asynchronous reset, active low
//  btn_i      in   N_BTN   raw asynchronous button inputs
//  clr_i      in   N_BTN   per-channel pending-clear, synchronous to clk_i
//  level_o    out  N_BTN   debounced level, 1 = pressed (polarity normalised)
//  press_o    out  N_BTN   1-cycle pulse on accepted press (and on each auto-repeat)
//  release_o  out  N_BTN   1-cycle pulse on accepted release
//  pend_o     out  N_BTN   sticky: set by press_o, cleared by clr_i
// BEHAVIOUR
//  Reset (rstn=0, async): sync FFs load "released" value; counters 0; all outputs 0.
//  Reset release mid-bounce: the first accepted level is "released"; a held button yields press_o
//   after a full debounce.
//  Sync: btn_i -> s1 -> s2; XOR with ACTIVE_LOW gives raw (1 = pressed).
//  Debounce: each clock, raw==level -> cnt<=0.
//   raw!=level and cnt<DEB_CYCLES-1 -> cnt++.
//   raw!=level and cnt==DEB_CYCLES-1 -> level toggles and cnt<=0.
//   Any bounce back to level restarts the count from 0.
//  Latency: for a clean step, level_o changes on the (DEB_CYCLES+2)th rising edge after the first edge
//   sampling the new btn_i. press_o/release_o assert on that same edge, high for exactly 1 cycle.
//  Pulses are registered outputs; press_o and release_o on the same channel are never high together.
//  pend_o: set on press_o; cleared on clr_i. Same-cycle press_o and clr_i -> pend_o stays 1 (set wins).
//   clr_i with pend_o=0 is ignored.
//  Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
//  Counter width: $clog2(DEB_CYCLES), saturates by construction and never wraps.
// CONFIGURATION
//  `BTN_AUTOREPEAT_EN defined:
//   - While level_o=1, a repeat counter runs.
//   - First extra press_o after REPEAT_DELAY clocks from the accepted press, then every REPEAT_PERIOD clocks.
//   - Each extra press_o sets pend_o.
//   - The counter clears on release or reset.
//   - release_o is unaffected.
//  `BTN_AUTOREPEAT_EN undefined:
//   - One press_o per accepted press only; repeat logic and REPEAT_* parameters are unused.
// STRUCTURE
//  Shared package sawtooth_pkg:
//   - BTN_DEB_DEFAULT and REPEAT defaults as localparams.
//   - btn_evt_t (struct {level, press, release, pend}).
//   - Constant function clog2 for counter widths.
//  Sub-module btn_debounce_ch (one channel: sync, counter, edge/pulse, pend, optional repeat).
//  button_conditioner instantiates it N_BTN times in a generate loop; no shared logic between channels.
// TESTING (DEB_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=10, ACTIVE_LOW=1, N_BTN=3)
//  1 Reset: rstn=0 with btn_i=3'b000 (all pressed) -> all outputs 0.
//    After release, press_o=3'b111 exactly on edge 10 after reset deassertion.
//  2 Clean press ch0: btn_i[0] 1->0 held -> level_o[0]=1 and press_o[0]=1 for 1 cycle on edge 10.
//    pend_o[0]=1 and stays 1.
//  3 Bounce: btn_i[0] toggles every 3 clocks for 30 clocks, then holds low
//    -> no press_o during bounce; single press_o 10 edges after last toggle.
//  4 Release ch1 after press -> release_o[1] 1 cycle; level_o[1]=0; pend_o[1] unchanged.
//  5 Handshake: clr_i[0] asserted on the same cycle as a new press_o[0] -> pend_o[0]=1.
//    clr_i[0] next cycle -> pend_o[0]=0.
//  6 BTN_AUTOREPEAT_EN, ch2 held 60 clocks after acceptance -> press_o[2] at +0, +20, +30, +40, +50.
//    Without the macro -> only at +0.

Source files
------------

// File: rtl/sawtooth_pkg.sv
// ============================================================================
// Module      : sawtooth_pkg
// Description : Shared types, defaults and helpers for the button front end.
//               - BTN_DEB_DEFAULT / REPEAT_*_DEFAULT : default timing, clocks
//               - btn_evt_t : per-channel event bundle {level, press, rel, pend}
//               - clog2     : constant function for counter widths
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sawtooth_pkg;

    localparam int BTN_DEB_DEFAULT        = 1000000;   // 20 ms @ 50 MHz
    localparam int REPEAT_DELAY_DEFAULT   = 25000000;  // 500 ms @ 50 MHz
    localparam int REPEAT_PERIOD_DEFAULT  = 12500000;  // 250 ms @ 50 MHz

    // 'release' is a reserved word, so the release pulse field is 'rel'.
    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic pend;
    } btn_evt_t;

    // Bits needed to hold 0..v-1, never less than 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage : sawtooth_pkg

`default_nettype wire

// File: rtl/button_conditioner_if.sv
// ============================================================================
// Module      : button_conditioner_if
// Description : Bundle between raw keys / FSM side and the button conditioner.
//               btn_i, clr_i          : toward the conditioner
//               level_o, press_o,
//               release_o, pend_o     : from the conditioner
//               master = key/FSM side, slave = conditioner
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface button_conditioner_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] btn_i;
    logic [N_BTN-1:0] clr_i;
    logic [N_BTN-1:0] level_o;
    logic [N_BTN-1:0] press_o;
    logic [N_BTN-1:0] release_o;
    logic [N_BTN-1:0] pend_o;

    modport master (
        output btn_i, clr_i,
        input  level_o, press_o, release_o, pend_o
    );

    modport slave (
        input  btn_i, clr_i,
        output level_o, press_o, release_o, pend_o
    );
endinterface : button_conditioner_if

`default_nettype wire

// File: rtl/btn_debounce_ch.sv
// ============================================================================
// Module      : btn_debounce_ch
// Description : One button channel: 2-FF synchroniser, debounce counter,
//               registered press/release pulses, sticky pending flag and
//               optional auto-repeat (BTN_AUTOREPEAT_EN).
//   clk_i  in  system clock
//   rstn   in  asynchronous reset, active low
//   btn_i  in  raw asynchronous button
//   clr_i  in  pending-clear, synchronous to clk_i
//   evt_o  out {level, press, rel, pend}
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce_ch
    import sawtooth_pkg::*;
#(
    parameter int DEB_CYCLES    = BTN_DEB_DEFAULT,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT
) (
    input  wire logic clk_i,
    input  wire logic rstn,
    input  wire logic btn_i,
    input  wire logic clr_i,
    output btn_evt_t  evt_o
);

    localparam int            CW        = clog2(DEB_CYCLES);
    localparam logic [CW-1:0] c_cnt_max = CW'(DEB_CYCLES - 1);

    // Reject configurations the counters cannot represent.
    if (DEB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_chk_params
        $error("btn_debounce_ch: illegal timing parameters");
    end

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;
    logic          r_rel;
    logic          r_pend;

    logic w_raw;
    logic w_toggle;
    logic w_accept_press;
    logic w_accept_rel;
    logic w_rep_fire;
    logic w_press_set;

    // Normalised sample: 1 = pressed regardless of board polarity.
    assign w_raw          = r_s2 ^ ACTIVE_LOW;
    assign w_toggle       = (w_raw != r_level) && (r_cnt == c_cnt_max);
    assign w_accept_press = w_toggle && !r_level;
    assign w_accept_rel   = w_toggle &&  r_level;
    assign w_press_set    = w_accept_press || w_rep_fire;

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            // Synchroniser starts at the idle level so a key held through
            // reset still needs a full debounce before it reports a press.
            r_s1    <= ACTIVE_LOW;
            r_s2    <= ACTIVE_LOW;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
            r_rel   <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_s1    <= btn_i;
            r_s2    <= r_s1;
            r_level <= r_level ^ w_toggle;
            // Any sample agreeing with the level restarts the count; the
            // count is cleared on acceptance so it can never wrap.
            if (w_raw == r_level || w_toggle) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_press <= w_press_set;
            r_rel   <= w_accept_rel;
            // Set rises with press_o and is held through the cycle press_o is
            // visible, so a clear landing in that cycle cannot lose the event.
            if (w_press_set || r_press) begin
                r_pend <= 1'b1;
            end else if (clr_i) begin
                r_pend <= 1'b0;
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
    localparam logic [RW-1:0] c_rep_first = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] c_rep_next  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] r_rep_cnt;
    logic          r_rep_first;
    logic [RW-1:0] w_rep_tgt;

    assign w_rep_tgt  = r_rep_first ? c_rep_first : c_rep_next;
    // A repeat falling on the release edge is dropped so press and release
    // never pulse together.
    assign w_rep_fire = r_level && !w_toggle && (r_rep_cnt == w_rep_tgt);

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (!r_level || w_toggle) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b0;
        end else begin
            r_rep_cnt   <= r_rep_cnt + 1'b1;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    assign evt_o.level = r_level;
    assign evt_o.press = r_press;
    assign evt_o.rel   = r_rel;
    assign evt_o.pend  = r_pend;

endmodule : btn_debounce_ch

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module      : button_conditioner
// Description : N_BTN independent button channels (sync, debounce, pulses,
//               sticky pending flag). Optional auto-repeat is enabled by
//               defining the macro BTN_AUTOREPEAT_EN.
//   clk_i  in   system clock (50 MHz)
//   rstn   in   asynchronous reset, active low
//   bus    slave modport of button_conditioner_if:
//          btn_i, clr_i in; level_o, press_o, release_o, pend_o out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner
    import sawtooth_pkg::*;
#(
    parameter int N_BTN         = 3,
    parameter int DEB_CYCLES    = BTN_DEB_DEFAULT,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT
) (
    input  wire logic            clk_i,
    input  wire logic            rstn,
    button_conditioner_if.slave  bus
);

    btn_evt_t         w_evt [N_BTN];
    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_rel;
    logic [N_BTN-1:0] w_pend;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEB_CYCLES    (DEB_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk_i (clk_i),
            .rstn  (rstn),
            .btn_i (bus.btn_i[i]),
            .clr_i (bus.clr_i[i]),
            .evt_o (w_evt[i])
        );

        assign w_level[i] = w_evt[i].level;
        assign w_press[i] = w_evt[i].press;
        assign w_rel[i]   = w_evt[i].rel;
        assign w_pend[i]  = w_evt[i].pend;
    end

    assign bus.level_o   = w_level;
    assign bus.press_o   = w_press;
    assign bus.release_o = w_rel;
    assign bus.pend_o    = w_pend;

endmodule : button_conditioner

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner. Expected pulses
//               (edge number, press mask, release mask) are queued when the
//               stimulus is driven and popped when the DUT pulses.
//               Define BTN_AUTOREPEAT_EN to expect the auto-repeat pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_conditioner;

    localparam int N   = 3;
    localparam int DEB = 8;
    localparam int RD  = 20;
    localparam int RP  = 10;
    localparam int LAT = DEB + 2;

    typedef struct {
        int           cyc;
        logic [N-1:0] press;
        logic [N-1:0] rel;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    button_conditioner_if #(.N_BTN(N)) bif ();

    button_conditioner #(
        .N_BTN         (N),
        .DEB_CYCLES    (DEB),
        .ACTIVE_LOW    (1'b1),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk_i (clk),
        .rstn  (rstn),
        .bus   (bif.slave)
    );

    int   edge_cnt = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    exp_t sb [$];
    exp_t sb_e;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int tgt);
        while (edge_cnt < tgt) @(negedge clk);
    endtask

    task automatic push_exp(input int cyc, input logic [N-1:0] p, input logic [N-1:0] r);
        exp_t e;
        e.cyc   = cyc;
        e.press = p;
        e.rel   = r;
        sb.push_back(e);
    endtask

    // Scoreboard: every pulse cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (rstn && (bif.press_o != '0 || bif.release_o != '0)) begin
            if (sb.size() == 0) begin
                check_eq("spurious_pulse", 32'({bif.press_o, bif.release_o}), 32'd0);
            end else begin
                sb_e = sb.pop_front();
                check_eq("pulse_edge",   32'(edge_cnt),       32'(sb_e.cyc));
                check_eq("press_mask",   32'(bif.press_o),    32'(sb_e.press));
                check_eq("release_mask", 32'(bif.release_o),  32'(sb_e.rel));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: run did not finish, edge %0d", edge_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int acc;

        // 1: reset with all keys pressed
        bif.btn_i = 3'b000;
        bif.clr_i = 3'b000;
        rstn      = 1'b0;
        step(3);
        check_eq("rst_level",   32'(bif.level_o),   32'd0);
        check_eq("rst_press",   32'(bif.press_o),   32'd0);
        check_eq("rst_release", 32'(bif.release_o), 32'd0);
        check_eq("rst_pend",    32'(bif.pend_o),    32'd0);
        rstn = 1'b1;
        t = edge_cnt;
        push_exp(t + LAT, 3'b111, 3'b000);
        wait_until(t + LAT);
        check_eq("rst_held_level", 32'(bif.level_o), 32'b111);
        check_eq("rst_held_pend",  32'(bif.pend_o),  32'b111);

        bif.btn_i = 3'b111;
        t = edge_cnt;
        push_exp(t + LAT, 3'b000, 3'b111);
        wait_until(t + LAT);
        step(1);
        check_eq("all_rel_level", 32'(bif.level_o), 32'b000);
        check_eq("all_rel_pend",  32'(bif.pend_o),  32'b111);
        bif.clr_i = 3'b111;
        step(1);
        bif.clr_i = 3'b000;
        check_eq("clr_all_pend", 32'(bif.pend_o), 32'b000);

        // 2: clean press on ch0
        bif.btn_i[0] = 1'b0;
        t = edge_cnt;
        push_exp(t + LAT, 3'b001, 3'b000);
        wait_until(t + LAT);
        check_eq("press0_level", 32'(bif.level_o), 32'b001);
        check_eq("press0_pend",  32'(bif.pend_o),  32'b001);
        step(5);
        check_eq("press0_pend_held", 32'(bif.pend_o),  32'b001);
        check_eq("press0_one_cycle", 32'(bif.press_o), 32'b000);

        // 3: release ch0, then bounce and settle pressed
        bif.btn_i[0] = 1'b1;
        t = edge_cnt;
        push_exp(t + LAT, 3'b000, 3'b001);
        wait_until(t + LAT);
        step(2);
        for (int i = 0; i < 10; i++) begin
            bif.btn_i[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(3);
        end
        bif.btn_i[0] = 1'b0;
        t = edge_cnt;
        push_exp(t + LAT, 3'b001, 3'b000);
        wait_until(t + LAT);
        step(1);
        check_eq("bounce_level", 32'(bif.level_o), 32'b001);

        // 4: press then release ch1; pend unaffected by release
        bif.btn_i[1] = 1'b0;
        t = edge_cnt;
        push_exp(t + LAT, 3'b010, 3'b000);
        wait_until(t + LAT);
        step(2);
        check_eq("press1_pend", 32'(bif.pend_o), 32'b011);
        bif.btn_i[1] = 1'b1;
        t = edge_cnt;
        push_exp(t + LAT, 3'b000, 3'b010);
        wait_until(t + LAT);
        step(1);
        check_eq("rel1_level", 32'(bif.level_o), 32'b001);
        check_eq("rel1_pend",  32'(bif.pend_o),  32'b011);

        // 5: clear handshake, clear coinciding with a new press
        bif.clr_i = 3'b001;
        step(1);
        bif.clr_i = 3'b000;
        check_eq("clr0_pend", 32'(bif.pend_o), 32'b010);
        bif.btn_i[0] = 1'b1;
        t = edge_cnt;
        push_exp(t + LAT, 3'b000, 3'b001);
        wait_until(t + LAT);
        step(2);
        bif.btn_i[0] = 1'b0;
        t = edge_cnt;
        push_exp(t + LAT, 3'b001, 3'b000);
        wait_until(t + LAT);
        bif.clr_i[0] = 1'b1;
        step(1);
        check_eq("set_wins_pend", 32'(bif.pend_o[0]), 32'd1);
        step(1);
        bif.clr_i[0] = 1'b0;
        check_eq("clr_next_pend", 32'(bif.pend_o[0]), 32'd0);

        // 6: ch2 held 60 clocks after acceptance
        bif.btn_i[2] = 1'b0;
        t   = edge_cnt;
        acc = t + LAT;
        push_exp(acc, 3'b100, 3'b000);
`ifdef BTN_AUTOREPEAT_EN
        push_exp(acc + RD,          3'b100, 3'b000);
        push_exp(acc + RD + RP,     3'b100, 3'b000);
        push_exp(acc + RD + 2 * RP, 3'b100, 3'b000);
        push_exp(acc + RD + 3 * RP, 3'b100, 3'b000);
`endif
        wait_until(acc + 50);
        bif.btn_i[2] = 1'b1;
        push_exp(acc + 50 + LAT, 3'b000, 3'b100);
        wait_until(acc + 50 + LAT);
        step(2);
        check_eq("final_level", 32'(bif.level_o), 32'b001);
        check_eq("final_pend",  32'(bif.pend_o),  32'b110);
        check_eq("sb_drained",  32'(sb.size()),   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_button_conditioner

`default_nettype wire
